// File: rtl/simd_result_checker.sv
// Response-side checker for multi-lane SIMD results.
// Expected vectors are queued in a FIFO. Each DUT result is compared bit-exact,
// lane by lane, against the FIFO head. A settle window discards early results,
// and a run ends after NUM_CHECKS comparisons.
// Optional feature: define SIMD_CHECKER_LANE_MASK_EN to add the lane_mask_i port,
// which excludes lanes from comparison.
module simd_result_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SETTLE     = 5000,
    parameter int unsigned NUM_CHECKS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   exp_valid_i,
    output logic                   exp_ready_o,
    input  logic [LANES*WIDTH-1:0] exp_data_i,
    input  logic                   dut_valid_i,
    input  logic [LANES*WIDTH-1:0] dut_data_i,
`ifdef SIMD_CHECKER_LANE_MASK_EN
    input  logic [LANES-1:0]       lane_mask_i,
`endif
    output logic                   done_o,
    output logic                   pass_o,
    output logic [15:0]            err_count_o,
    output logic [15:0]            match_count_o,
    output logic [LANES-1:0]       lane_err_o,
    output logic                   underflow_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned VW = LANES * WIDTH;
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
    localparam logic [31:0] SettleLoad = (SETTLE == 0) ? 32'd0 : 32'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StRun, StDone} state_e;

    state_e           state_q;
    logic [VW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [31:0]      settle_q;
    logic [31:0]      checks_q;
    logic [15:0]      err_q;
    logic [15:0]      match_q;
    logic [LANES-1:0] lane_err_q;
    logic             underflow_q;

    logic [LANES-1:0] cmp_mask;
    logic [LANES-1:0] lane_diff;
    logic [VW-1:0]    head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             check;
    logic             last_check;

`ifdef SIMD_CHECKER_LANE_MASK_EN
    assign cmp_mask = lane_mask_i;
`else
    assign cmp_mask = '1;
`endif

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FullCount);
    assign exp_ready_o = !fifo_full && ((state_q == StSettle) || (state_q == StRun));
    assign push        = exp_valid_i && exp_ready_o;
    // Every RUN-state result is a check, even with an empty FIFO (underflow).
    assign check       = (state_q == StRun) && dut_valid_i;
    assign pop         = check && !fifo_empty;
    assign last_check  = check && ((checks_q + 32'd1) >= NUM_CHECKS);
    assign head        = mem_q[rd_ptr_q];

    // Per-lane raw bit inequality against the FIFO head, masked lanes excluded.
    always_comb begin
        lane_diff = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_diff[i] = cmp_mask[i] &&
                           (head[i*WIDTH +: WIDTH] != dut_data_i[i*WIDTH +: WIDTH]);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= exp_data_i;
        end
    end

    // Run FSM, FIFO pointers and result counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            settle_q    <= '0;
            checks_q    <= '0;
            err_q       <= '0;
            match_q     <= '0;
            lane_err_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q     <= (SETTLE == 0) ? StRun : StSettle;
                        settle_q    <= SettleLoad;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        count_q     <= '0;
                        checks_q    <= '0;
                        err_q       <= '0;
                        match_q     <= '0;
                        lane_err_q  <= '0;
                        underflow_q <= 1'b0;
                    end
                end
                StSettle: begin
                    if (settle_q == 32'd0) begin
                        state_q <= StRun;
                    end else begin
                        settle_q <= settle_q - 32'd1;
                    end
                end
                StRun: begin
                    if (check) begin
                        checks_q <= checks_q + 32'd1;
                        if (fifo_empty) begin
                            underflow_q <= 1'b1;
                            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                        end else if (lane_diff != '0) begin
                            lane_err_q <= lane_err_q | lane_diff;
                            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                        end else begin
                            if (match_q != 16'hFFFF) match_q <= match_q + 16'd1;
                        end
                        if (last_check) state_q <= StDone;
                    end
                end
            endcase

            // Push and pop never coincide with the start-time clear (IDLE/DONE).
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign done_o        = (state_q == StDone);
    assign pass_o        = done_o && (err_q == 16'd0) && !underflow_q;
    assign err_count_o   = err_q;
    assign match_count_o = match_q;
    assign lane_err_o    = lane_err_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_simd_result_checker.sv
// Self-checking bench for simd_result_checker: a cycle model with an expected-vector
// queue predicts every output; u_a runs 4-check scenarios, u_b the long FIFO-wrap run.
module tb_simd_result_checker;

    localparam int SETTLE_C = 4;
    localparam int DEPTH_C  = 8;
    localparam logic [31:0] VEC = 32'h0906_05FE;  // lanes 0..3 = FE,05,06,09

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    logic        dut_valid = 1'b0;
    logic [31:0] dut_data = '0;
`ifdef SIMD_CHECKER_LANE_MASK_EN
    logic [3:0]  lane_mask = 4'hF;
`endif

    logic        a_ready, a_done, a_pass, a_under;
    logic [15:0] a_err, a_match;
    logic [3:0]  a_lane;
    logic        b_ready, b_done, b_pass, b_under;
    logic [15:0] b_err, b_match;
    logic [3:0]  b_lane;

    always #5 clock = ~clock;

    simd_result_checker #(.WIDTH(8), .LANES(4), .DEPTH(DEPTH_C), .SETTLE(SETTLE_C),
                          .NUM_CHECKS(4)) u_a (
        .clock(clock), .reset(reset), .start_i(start && !sel),
        .exp_valid_i(exp_valid), .exp_ready_o(a_ready), .exp_data_i(exp_data),
        .dut_valid_i(dut_valid), .dut_data_i(dut_data),
`ifdef SIMD_CHECKER_LANE_MASK_EN
        .lane_mask_i(lane_mask),
`endif
        .done_o(a_done), .pass_o(a_pass), .err_count_o(a_err), .match_count_o(a_match),
        .lane_err_o(a_lane), .underflow_o(a_under)
    );

    simd_result_checker #(.WIDTH(8), .LANES(4), .DEPTH(DEPTH_C), .SETTLE(SETTLE_C),
                          .NUM_CHECKS(24)) u_b (
        .clock(clock), .reset(reset), .start_i(start && sel),
        .exp_valid_i(exp_valid), .exp_ready_o(b_ready), .exp_data_i(exp_data),
        .dut_valid_i(dut_valid), .dut_data_i(dut_data),
`ifdef SIMD_CHECKER_LANE_MASK_EN
        .lane_mask_i(lane_mask),
`endif
        .done_o(b_done), .pass_o(b_pass), .err_count_o(b_err), .match_count_o(b_match),
        .lane_err_o(b_lane), .underflow_o(b_under)
    );

    // Observed outputs of whichever instance the current scenario targets.
    logic        o_ready, o_done, o_pass, o_under;
    logic [15:0] o_err, o_match;
    logic [3:0]  o_lane;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_done  = sel ? b_done  : a_done;
    assign o_pass  = sel ? b_pass  : a_pass;
    assign o_under = sel ? b_under : a_under;
    assign o_err   = sel ? b_err   : a_err;
    assign o_match = sel ? b_match : a_match;
    assign o_lane  = sel ? b_lane  : a_lane;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    typedef enum int {MIdle, MSettle, MRun, MDone} mstate_e;
    mstate_e     ms = MIdle;
    int          mcnt = 0;
    logic [31:0] mq[$];
    int          m_match = 0;
    int          m_err = 0;
    int          m_checks = 0;
    logic [3:0]  m_lane = '0;
    logic        m_under = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_match = 0; m_err = 0; m_checks = 0; m_lane = '0; m_under = 1'b0;
    endtask

    // Advance one clock: predict from current inputs, then compare every output.
    task automatic cyc();
        logic        rdy;
        logic        pushed;
        logic [3:0]  mask;
        logic [3:0]  diff;
        logic [31:0] head;
        int          nchk;
        nchk = sel ? 24 : 4;
        rdy = ((ms == MSettle) || (ms == MRun)) && (mq.size() < DEPTH_C);
        chk("exp_ready", 32'(o_ready), 32'(rdy));
        pushed = exp_valid && rdy;
`ifdef SIMD_CHECKER_LANE_MASK_EN
        mask = lane_mask;
`else
        mask = 4'hF;
`endif
        if (!reset) begin
            ms = MIdle;
            model_clear();
        end else begin
            case (ms)
                MIdle, MDone: begin
                    if (start) begin
                        ms = MSettle;
                        mcnt = SETTLE_C - 1;
                        model_clear();
                    end
                end
                MSettle: begin
                    if (pushed) mq.push_back(exp_data);
                    if (mcnt == 0) ms = MRun;
                    else mcnt--;
                end
                MRun: begin
                    if (dut_valid) begin
                        if (mq.size() > 0) begin
                            head = mq.pop_front();
                            for (int i = 0; i < 4; i++)
                                diff[i] = mask[i] && (head[i*8 +: 8] != dut_data[i*8 +: 8]);
                            if (diff != 4'b0) begin
                                m_err++;
                                m_lane = m_lane | diff;
                            end else begin
                                m_match++;
                            end
                        end else begin
                            m_under = 1'b1;
                            m_err++;
                        end
                        m_checks++;
                        if (m_checks == nchk) ms = MDone;
                    end
                    if (pushed) mq.push_back(exp_data);
                end
                default: ms = MIdle;
            endcase
        end
        @(posedge clock);
        #1;
        chk("done", 32'(o_done), 32'(ms == MDone));
        chk("pass", 32'(o_pass), 32'((ms == MDone) && (m_err == 0) && !m_under));
        chk("err_count", 32'(o_err), 32'(m_err));
        chk("match_count", 32'(o_match), 32'(m_match));
        chk("lane_err", 32'(o_lane), 32'(m_lane));
        chk("underflow", 32'(o_under), 32'(m_under));
    endtask

    task automatic drive(input logic ev, input logic [31:0] ed,
                         input logic dv, input logic [31:0] dd);
        exp_valid = ev; exp_data = ed; dut_valid = dv; dut_data = dd;
        cyc();
        exp_valid = 1'b0; exp_data = '0; dut_valid = 1'b0; dut_data = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Prefill four VEC during settle, then return four results; bad_idx gets bad_vec.
    task automatic run4(input int bad_idx, input logic [31:0] bad_vec);
        pulse_start();
        for (int i = 0; i < 4; i++) drive(1'b1, VEC, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, (i == bad_idx) ? bad_vec : VEC);
    endtask

    initial begin
        logic [31:0] r;
        // Reset state
        reset = 1'b0;
        cyc();
        cyc();
        chk("reset_done", 32'(a_done), 32'd0);
        chk("reset_ready", 32'(a_ready), 32'd0);
        reset = 1'b1;
        cyc();

        // 1: clean run, FE is bit-identical to -2
        run4(-1, '0);
        chk("t1_match", 32'(o_match), 32'd4);
        chk("t1_pass", 32'(o_pass), 32'd1);
        cyc();
        chk("t1_done_held", 32'(o_done), 32'd1);

        // 2: lane 2 of vector 1 returns 07 instead of 06
        run4(1, 32'h0907_05FE);
        chk("t2_err", 32'(o_err), 32'd1);
        chk("t2_lane_err", 32'(o_lane), 32'b0100);
        chk("t2_match", 32'(o_match), 32'd3);
        chk("t2_pass", 32'(o_pass), 32'd0);

        // 3: results during settle are dropped; empty-FIFO result underflows
        pulse_start();
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, VEC);
        chk("t3_settle_err", 32'(o_err), 32'd0);
        drive(1'b1, VEC, 1'b1, VEC);  // underflow; push lands for next result
        chk("t3_underflow", 32'(o_under), 32'd1);
        chk("t3_err", 32'(o_err), 32'd1);
        drive(1'b1, VEC, 1'b1, VEC);
        drive(1'b1, VEC, 1'b1, VEC);
        drive(1'b0, '0, 1'b1, VEC);
        chk("t3_done", 32'(o_done), 32'd1);
        chk("t3_pass", 32'(o_pass), 32'd0);

        // 5: reset mid-run clears everything, next run is clean
        pulse_start();
        for (int i = 0; i < 4; i++) drive(1'b1, VEC, 1'b0, '0);
        drive(1'b0, '0, 1'b1, VEC);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("t5_match", 32'(o_match), 32'd0);
        chk("t5_ready", 32'(o_ready), 32'd0);
        run4(-1, '0);
        chk("t5_pass", 32'(o_pass), 32'd1);

        // 6: lane 2 corrupted under lane_mask 1011
`ifdef SIMD_CHECKER_LANE_MASK_EN
        lane_mask = 4'b1011;
`endif
        run4(2, 32'h0933_05FE);
`ifdef SIMD_CHECKER_LANE_MASK_EN
        chk("t6_pass", 32'(o_pass), 32'd1);
        chk("t6_lane_err", 32'(o_lane), 32'd0);
        lane_mask = 4'hF;
`else
        chk("t6_pass", 32'(o_pass), 32'd0);
        chk("t6_lane_err", 32'(o_lane), 32'b0100);
`endif

        // 4: fill to DEPTH, then streamed push/pop across pointer wrap
        sel = 1'b1;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            r = $urandom;
            drive(1'b1, r, 1'b0, '0);
        end
        chk("t4_full_ready", 32'(o_ready), 32'd0);
        drive(1'b0, '0, 1'b1, mq[0]);
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            drive(1'b1, r, 1'b1, mq[0]);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, mq[0]);
        chk("t4_match", 32'(o_match), 32'd24);
        chk("t4_err", 32'(o_err), 32'd0);
        chk("t4_pass", 32'(o_pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
